// File: rtl/phase_pkg.sv
// Shared phase-bus definitions for the phase sequence monitor: code values,
// error codes, tracking states and the legal-transition table.
package phase_pkg;

  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_1       = 3'd1;
  localparam logic [2:0] PH_2       = 3'd2;
  localparam logic [2:0] PH_3       = 3'd3;
  localparam logic [2:0] PH_4       = 3'd4;
  localparam logic [2:0] PH_5       = 3'd5;
  localparam logic [2:0] PH_BAD     = 3'd6;
  localparam logic [2:0] PH_RESTART = 3'd7;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BADCODE = 2'd1;
  localparam logic [1:0] ERR_TRANS   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_RUN,
    TRK_RESTART,
    TRK_INVALID
  } trk_e;

  function automatic trk_e track_of(input logic [2:0] code);
    case (code)
      PH_IDLE:                      return TRK_IDLE;
      PH_1, PH_2, PH_3, PH_4, PH_5: return TRK_RUN;
      PH_RESTART:                   return TRK_RESTART;
      default:                      return TRK_INVALID;
    endcase
  endfunction

  // A previous code of 6 has no legal successor; every move out of it is illegal.
  function automatic logic is_legal(input logic [2:0] prev, input logic [2:0] cur);
    case (prev)
      PH_IDLE:                return (cur == PH_IDLE) || (cur == PH_1);
      PH_1, PH_2, PH_3, PH_4: return (cur == prev + 3'd1) || (cur == PH_RESTART);
      PH_5:                   return (cur == PH_IDLE) || (cur == PH_RESTART);
      PH_RESTART:             return (cur == PH_RESTART) || (cur == PH_1);
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/phase_stall_timer.sv
// Counts consecutive 7->7 holds and flags the single transition on which the
// count first exceeds STALL_MAX; the count then freezes until 7 is left.
module phase_stall_timer #(
  parameter int STALL_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic timeout
);

  localparam int CW = $clog2(STALL_MAX + 2);
  localparam logic [CW-1:0] LIMIT   = CW'(STALL_MAX);
  localparam logic [CW-1:0] EXPIRED = CW'(STALL_MAX + 1);

  logic [CW-1:0] count;

  assign timeout = hold && (count == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!hold) begin
      count <= '0;
    end else if (count != EXPIRED) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/phase_seq_monitor.sv
// Receive-side checker for the 3-bit phase bus: registered status strobes,
// saturating sequence count and first-error capture.
// Optional stall timeout on held restart code: define PHASE_MON_TIMEOUT_EN.
module phase_seq_monitor
  import phase_pkg::*;
#(
  parameter int SEQ_W     = 8,
  parameter int STALL_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cnt_in,
  input  logic             clr,
  output logic             busy,
  output logic             step,
  output logic             done,
  output logic             restart,
  output logic [SEQ_W-1:0] seq_cnt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [5:0]       err_info
);

  logic [2:0] prev;
  trk_e       trk;
  logic       legal;
  logic       step_c;
  logic       done_c;
  logic       restart_c;
  logic       timeout;
  logic [1:0] new_err;

  assign trk = track_of(prev);

`ifdef PHASE_MON_TIMEOUT_EN
  phase_stall_timer #(
    .STALL_MAX (STALL_MAX)
  ) u_stall_timer (
    .clk     (clk),
    .rst     (rst),
    .hold    ((prev == PH_RESTART) && (cnt_in == PH_RESTART)),
    .timeout (timeout)
  );
`else
  logic unused_stall_max;
  assign unused_stall_max = (STALL_MAX > 0);
  assign timeout          = 1'b0;
`endif

  // Every legal transition that lands on a run code is an advance (0->1, n->n+1, 7->1).
  always_comb begin
    legal     = is_legal(prev, cnt_in);
    step_c    = legal && (cnt_in inside {[PH_1:PH_5]});
    done_c    = (prev == PH_5) && (cnt_in == PH_IDLE);
    restart_c = (trk == TRK_RUN) && (cnt_in == PH_RESTART);
    if (cnt_in == PH_BAD)  new_err = ERR_BADCODE;
    else if (!legal)       new_err = ERR_TRANS;
    else if (timeout)      new_err = ERR_TIMEOUT;
    else                   new_err = ERR_NONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of prev and the error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= PH_IDLE;
      busy     <= 1'b0;
      step     <= 1'b0;
      done     <= 1'b0;
      restart  <= 1'b0;
      seq_cnt  <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      err_info <= '0;
    end else begin
      prev    <= cnt_in;
      busy    <= cnt_in inside {[PH_1:PH_5]};
      step    <= step_c;
      done    <= done_c;
      restart <= restart_c;

      if (clr)                            seq_cnt <= '0;
      else if (done_c && (seq_cnt != '1)) seq_cnt <= seq_cnt + 1'b1;

      // A clear on the same edge as a new error still lets that error in as the first.
      if ((new_err != ERR_NONE) && (!err || clr)) begin
        err      <= 1'b1;
        err_code <= new_err;
        err_info <= {prev, cnt_in};
      end else if (clr) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
        err_info <= '0;
      end
    end
  end

endmodule

// File: tb/tb_phase_seq_monitor.sv
// Directed and randomized checks of phase_seq_monitor against a pair-table
// reference model; expectations follow PHASE_MON_TIMEOUT_EN when defined.
module tb_phase_seq_monitor;

  localparam int SEQ_W     = 2;
  localparam int STALL_MAX = 4;
  localparam int CNT_MAX   = (1 << SEQ_W) - 1;
`ifdef PHASE_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       cnt_in = 3'd0;
  logic             clr = 1'b0;
  logic             busy, step, done, restart, err;
  logic [SEQ_W-1:0] seq_cnt;
  logic [1:0]       err_code;
  logic [5:0]       err_info;

  phase_seq_monitor #(
    .SEQ_W     (SEQ_W),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .clr      (clr),
    .busy     (busy),
    .step     (step),
    .done     (done),
    .restart  (restart),
    .seq_cnt  (seq_cnt),
    .err      (err),
    .err_code (err_code),
    .err_info (err_info)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  // Legal transitions written out as explicit (prev, cur) pairs.
  typedef struct { int p; int c; } pair_t;
  pair_t legal_q[$];

  int m_prev, m_err, m_code, m_info, m_cnt, m_stall;
  int e_busy, e_step, e_done, e_restart;

  function automatic bit in_legal(input int p, input int c);
    foreach (legal_q[i]) if (legal_q[i].p == p && legal_q[i].c == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (%s): observed=%0h expected=%0h", tag, phase, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("busy",     32'(busy),     32'(e_busy));
    check("step",     32'(step),     32'(e_step));
    check("done",     32'(done),     32'(e_done));
    check("restart",  32'(restart),  32'(e_restart));
    check("seq_cnt",  32'(seq_cnt),  32'(m_cnt));
    check("err",      32'(err),      32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
    check("err_info", 32'(err_info), 32'(m_info));
  endtask

  task automatic model_reset();
    m_prev = 0; m_err = 0; m_code = 0; m_info = 0; m_cnt = 0; m_stall = 0;
    e_busy = 0; e_step = 0; e_done = 0; e_restart = 0;
  endtask

  task automatic model_edge(input int cur, input bit c);
    bit lg, to;
    int code;
    lg        = in_legal(m_prev, cur);
    e_busy    = (cur >= 1 && cur <= 5);
    e_step    = lg && ((cur == m_prev + 1) || (m_prev == 7 && cur == 1));
    e_done    = lg && (m_prev == 5) && (cur == 0);
    e_restart = (m_prev >= 1 && m_prev <= 5) && (cur == 7);
    to = 1'b0;
    if (TO_EN) begin
      if (m_prev == 7 && cur == 7) m_stall++;
      else m_stall = 0;
      to = (m_stall == STALL_MAX + 1);
    end
    if (cur == 6)  code = 1;
    else if (!lg)  code = 2;
    else if (to)   code = 3;
    else           code = 0;
    if (c) m_cnt = 0;
    else if (e_done && m_cnt < CNT_MAX) m_cnt++;
    if (code != 0 && (m_err == 0 || c)) begin
      m_err = 1; m_code = code; m_info = m_prev * 8 + cur;
    end else if (c) begin
      m_err = 0; m_code = 0; m_info = 0;
    end
    m_prev = cur;
  endtask

  task automatic cycle(input int code, input bit c);
    @(negedge clk);
    cnt_in = code[2:0];
    clr    = c;
    @(posedge clk);
    model_edge(code, c);
    #1;
    compare_all();
  endtask

  task automatic run(input string name, input int q[$]);
    phase = name;
    foreach (q[i]) cycle(q[i], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    cnt_in = 3'd0;
    clr = 1'b0;
  endtask

  initial begin
    int q[$];
    int cand[$];
    int nxt;
    bit c;

    legal_q.push_back('{0, 0});
    legal_q.push_back('{0, 1});
    for (int n = 1; n <= 4; n++) legal_q.push_back('{n, n + 1});
    legal_q.push_back('{5, 0});
    for (int n = 1; n <= 5; n++) legal_q.push_back('{n, 7});
    legal_q.push_back('{7, 7});
    legal_q.push_back('{7, 1});

    phase = "reset";
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compare_all();
    rst = 1'b1;
    q = {0, 0, 0, 0, 0};
    run("idle", q);

    q = {0, 1, 2, 3, 4, 5, 0};
    run("full_seq", q);
    check("seq_cnt_after_one", 32'(seq_cnt), 32'd1);

    q = {0, 1, 2, 7, 7, 1, 2, 3, 4, 5, 0};
    run("restart_seq", q);
    check("err_after_restart", 32'(err), 32'd0);

    q = {0, 1, 3};
    run("skip_err", q);
    check("skip_code", 32'(err_code), 32'd2);
    q = {6};
    run("bad_after_skip", q);
    check("first_err_info", 32'(err_info), 32'b001_011);
    q = {0};
    run("resync", q);
    phase = "clear";
    cycle(0, 1'b1);
    check("err_cleared", 32'(err), 32'd0);
    check("code_cleared", 32'(err_code), 32'd0);

    for (int k = 0; k < 4; k++) begin
      q = {1, 2, 3, 4, 5, 0};
      run("saturate", q);
    end
    check("seq_cnt_saturated", 32'(seq_cnt), 32'(CNT_MAX));
    q = {1, 2, 3, 4, 5};
    run("fifth_seq", q);
    phase = "clr_with_done";
    cycle(0, 1'b1);
    check("seq_cnt_clr_done", 32'(seq_cnt), 32'd0);

    q = {1, 7, 7, 7, 7, 7, 7};
    run("stall", q);
    if (TO_EN) begin
      check("stall_code", 32'(err_code), 32'd3);
      check("stall_info", 32'(err_info), 32'b111_111);
    end else begin
      check("stall_no_err", 32'(err), 32'd0);
    end
    q = {7, 7, 1, 2, 3, 4, 5, 0};
    run("stall_exit", q);
    phase = "clear2";
    cycle(0, 1'b1);

    q = {0, 1, 2};
    run("pre_reset", q);
    phase = "mid_reset";
    do_reset();
    q = {3};
    run("after_reset", q);
    check("reset_resync_code", 32'(err_code), 32'd2);
    check("reset_resync_info", 32'(err_info), 32'b000_011);

    phase = "random";
    for (int k = 0; k < 400; k++) begin
      cand.delete();
      foreach (legal_q[i]) if (legal_q[i].p == m_prev) cand.push_back(legal_q[i].c);
      if (cand.size() > 0 && $urandom_range(0, 7) != 0)
        nxt = cand[$urandom_range(0, cand.size() - 1)];
      else
        nxt = int'($urandom_range(0, 7));
      c = ($urandom_range(0, 15) == 0);
      cycle(nxt, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_seq_monitor.md
Name: phase_seq_monitor

Overview:
Receive-side checker for the 3-bit phase code driven by the 6-phase sequencer (codes 0 idle, 1..5 run, 7 restart).
- Samples the code every clock and decodes it into registered status strobes.
- Checks every transition against the sequencer's legal transition set and counts completed sequences.
- Sits on the consumer side of the phase bus; its outputs feed control logic and debug status.

Parameters:
SEQ_W, 8, width of completed-sequence counter (saturating)
STALL_MAX, 16, max consecutive cycles code 7 may be held (used only with timeout feature)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
cnt_in  input  3  phase code from sequencer
clr  input  1  synchronous clear of err/err_code/err_info/seq_cnt
busy  output  1  registered: last sampled code in 1..5
step  output  1  one-cycle pulse on legal advance n->n+1 (n=0..4) or 7->1
done  output  1  one-cycle pulse on legal 5->0
restart  output  1  one-cycle pulse on entry to 7 from 1..5
seq_cnt  output  SEQ_W  completed sequences, saturating
err  output  1  sticky protocol error flag
err_code  output  2  0 none, 1 bad code (6), 2 illegal transition, 3 timeout
err_info  output  6  {prev,cur} codes of first error

Behaviour:
- Reset (rst=0, async): prev=0, all outputs 0, stall counter 0.
- Each rising edge: cur=cnt_in; transition (prev,cur) evaluated; outputs registered at that edge; prev<=cur. Latency: one edge after the code appears on cnt_in.
- Legal set: 0->0, 0->1, n->n+1 (n=1..4), 5->0, n->7 (n=1..5), 7->7, 7->1. Everything else is illegal, including 0->7, n->n for n=1..5, skips, and backward moves.
- Tracking states (derived from prev): IDLE (0), RUN (1..5), RESTART (7).
- Strobes:
  - step on 0->1, n->n+1, 7->1.
  - done on 5->0.
  - restart on 1..5->7 only; 7->7 gives no pulse.
- seq_cnt increments on done and saturates at 2^SEQ_W-1.
- Errors:
  - cur==6 gives err_code 1, regardless of prev.
  - Other illegal transitions give err_code 2.
  - Only the first error sets err_code/err_info; err stays high until clr.
- Strobes are generated from the legal table even while err=1. Illegal transitions produce no strobe.
- After any transition, prev tracks cur, so the monitor resynchronises.
- Simultaneous events:
  - clr with done: seq_cnt<=0.
  - clr with a new error: the new error is captured (err=1 with new code/info).
- Reset mid-sequence: prev returns to 0, so a following code such as 3 flags 0->3 illegal. This is intended; sequencer and monitor share rst.

Optional Feature:
PHASE_MON_TIMEOUT_EN
- Defined:
  - A stall counter counts consecutive cycles with prev==7 and cur==7, and clears on any other transition.
  - When the count exceeds STALL_MAX, the monitor raises error code 3 (first-error rule applies) and err_info={7,7}.
  - The counter then holds until 7 is exited.
- Undefined: no stall counter, 7 may be held indefinitely, and err_code 3 is never produced.

Decomposition:
- Package phase_pkg:
  - Code localparams PH_IDLE=0, PH_1..PH_5, PH_BAD=6, PH_RESTART=7.
  - Err code localparams ERR_NONE, ERR_BADCODE, ERR_TRANS, ERR_TIMEOUT.
  - Function is_legal(prev,cur).
- Sub-module phase_stall_timer (stall counter plus threshold compare), instantiated only under PHASE_MON_TIMEOUT_EN. All other logic stays in the top module.

Test Plan:
- Reset, then cnt_in=0 for 5 cycles -> busy=step=done=restart=err=0, seq_cnt=0.
- 0,1,2,3,4,5,0 -> step 5 pulses, busy high for 5 cycles, done once, seq_cnt=1, err=0.
- 0,1,2,7,7,1,2,3,4,5,0 -> restart once (on 2->7), no pulse on 7->7, seq_cnt=1, err=0.
- 0,1,3, then 6 -> err=1, err_code=2, err_info=6'b001_011 unchanged by the 6; then clr -> err=0, err_code=0.
- SEQ_W=2, 4 full sequences -> seq_cnt=3 (saturated); clr on the same edge as a 5th done -> seq_cnt=0.
- Macro on, STALL_MAX=4, 1 then 7 held 6 cycles -> err_code=3, err_info=6'b111_111. Macro off, same stimulus -> err=0.
